memory_access: RTL and testbench

//  Y86-64 SEQ memory stage, directly downstream of execute: consumes icode/valE/valA/valP,

---
 rtl/memory_access_pkg.sv | 64 ++++++
 rtl/memory_access_if.sv | 26 ++
 rtl/data_mem_byte.sv | 25 ++
 rtl/memory_access.sv | 173 +++++++++++++++++
 tb/tb_memory_access.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// Shared Y86-64 definitions for the memory stage: icodes, stat codes, FSM states
// and the request-decode helpers.
package memory_access_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // RD_TAIL absorbs the one-cycle RAM read latency of the final byte.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_TAIL,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_WR,
    ACC_RD
  } acc_e;

  // Which kind of data-memory access an icode needs.
  function automatic acc_e acc_kind(input logic [3:0] icode);
    acc_e k;
    case (icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: k = ACC_WR;
      I_MRMOVQ, I_POPQ, I_RET:   k = ACC_RD;
      default:                   k = ACC_NONE;
    endcase
    return k;
  endfunction

  // Final status, highest priority first: fetch error, illegal icode,
  // data address error, halt.
  function automatic logic [2:0] stat_select(input logic       imem_error,
                                             input logic       instr_valid,
                                             input logic       dmem_error,
                                             input logic [3:0] icode);
    logic [2:0] s;
    if (imem_error)          s = STAT_ADR;
    else if (!instr_valid)   s = STAT_INS;
    else if (dmem_error)     s = STAT_ADR;
    else if (icode == I_HALT) s = STAT_HLT;
    else                     s = STAT_AOK;
    return s;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Request/response bundle between the SEQ sequencer (master) and the memory
// stage (slave).
interface memory_access_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        done;
  logic        busy;
  logic        halted;

  modport master (
    output start, icode, valE, valA, valP, instr_valid, imem_error,
    input  valM, stat, done, busy, halted
  );

  modport slave (
    input  start, icode, valE, valA, valP, instr_valid, imem_error,
    output valM, stat, done, busy, halted
  );
endinterface

// File: rtl/data_mem_byte.sv
// Byte-wide data memory: one write port, synchronous read with one cycle of
// latency. Contents are deliberately not reset.
module data_mem_byte #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [MEM_BYTES];
  logic [7:0] rdata_q;

  // Write-first is irrelevant here: reads and writes never share a beat.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_access.sv
// Y86-64 SEQ memory stage. Performs the byte-serial (8-beat, little-endian)
// data-memory read or write an instruction needs and reports valM and the
// final status with a one-cycle done pulse.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic           clk,
  input  logic           reset,
  memory_access_if.slave bus
);

  // Highest start address whose 8 bytes still fit in memory.
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       sr_q, sr_d;
  logic [2:0]        stat_pend_q, stat_pend_d;
  logic              is_rd_q, is_rd_d;
  logic              rd_vld_q, rd_vld_d;
  logic              done_q, done_d;
  logic [2:0]        stat_q, stat_d;
  logic [63:0]       valm_q, valm_d;
  logic              halted_q, halted_d;

  acc_e              req_acc;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              req_dmem_err;
  logic [2:0]        req_stat;
  logic              req_go;
  logic              accept;

  logic              mem_we;
  logic              fsm_we;
  logic [7:0]        mem_rdata;

  // Decode the request presented alongside start: address, store data, status.
  always_comb begin
    req_acc   = acc_kind(bus.icode);
    req_addr  = bus.valE;
    req_wdata = bus.valA;
    case (bus.icode)
      I_POPQ, I_RET: req_addr  = bus.valA;
      I_CALL:        req_wdata = bus.valP;
      default:       ;
    endcase
    // Full 64-bit compare so a huge address can never alias into memory.
    req_dmem_err = (req_acc != ACC_NONE) && (req_addr > ADDR_MAX);
    req_stat     = stat_select(bus.imem_error, bus.instr_valid, req_dmem_err, bus.icode);
    req_go       = (req_acc != ACC_NONE) && (req_stat == STAT_AOK);
    accept       = (state_q == ST_IDLE) && !halted_q && bus.start;
  end

  // Next-state, beat sequencing, read assembly and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sr_d        = sr_q;
    stat_pend_d = stat_pend_q;
    is_rd_d     = is_rd_q;
    done_d      = 1'b0;
    stat_d      = stat_q;
    valm_d      = valm_q;
    halted_d    = halted_q;
    fsm_we      = 1'b0;
    rd_vld_d    = (state_q == ST_RD);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stat_pend_d = req_stat;
          cnt_d       = 3'd0;
          addr_d      = req_addr[ADDR_W-1:0];
          is_rd_d     = 1'b0;
          if (req_go && req_acc == ACC_WR) begin
            sr_d    = req_wdata;
            state_d = ST_WR;
          end else if (req_go && req_acc == ACC_RD) begin
            is_rd_d = 1'b1;
            state_d = ST_RD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WR: begin
        // Low byte goes out first; the store word shifts right each beat.
        fsm_we = 1'b1;
        sr_d   = sr_q >> 8;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_RESP;
      end
      ST_RD: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_RD_TAIL;
      end
      ST_RD_TAIL: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        stat_d  = stat_pend_q;
        if (is_rd_q) valm_d = sr_q;
        if (stat_pend_q != STAT_AOK) halted_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Each returned byte enters at the top, so after 8 beats byte 0 sits at the LSB.
    if (rd_vld_q) sr_d = {mem_rdata, sr_q[63:8]};
  end

  // Control state; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      stat_pend_q <= STAT_AOK;
      is_rd_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      stat_q      <= STAT_AOK;
      valm_q      <= 64'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stat_pend_q <= stat_pend_d;
      is_rd_q     <= is_rd_d;
      rd_vld_q    <= rd_vld_d;
      done_q      <= done_d;
      stat_q      <= stat_d;
      valm_q      <= valm_d;
      halted_q    <= halted_d;
    end
  end

  // Address and data shift registers carry no reset; they are loaded on accept.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    sr_q   <= sr_d;
  end

  // A reset arriving mid-write must stop the very next byte from landing.
  assign mem_we = fsm_we && !reset;

  data_mem_byte #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (sr_q[7:0]),
    .rdata (mem_rdata)
  );

  assign bus.valM   = valm_q;
  assign bus.stat   = stat_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized traffic checked
// against a byte-array model of data memory and the instruction rules.
module tb_memory_access;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  memory_access_if bus();

  memory_access #(
    .MEM_BYTES (1024),
    .ADDR_W    (10)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mdl_mem [1024];
  logic [63:0] mdl_valm;
  bit          mdl_halt;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst valM",   bus.valM,   64'd0);
    check_val("rst stat",   bus.stat,   64'd1);
    check_val("rst done",   bus.done,   64'd0);
    check_val("rst busy",   bus.busy,   64'd0);
    check_val("rst halted", bus.halted, 64'd0);
    reset    = 1'b0;
    mdl_valm = 64'd0;
    mdl_halt = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that samples start.
  task automatic drive_start(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                             input logic [63:0] p, input logic iv, input logic ie);
    bus.icode       = ic;
    bus.valE        = e;
    bus.valA        = a;
    bus.valP        = p;
    bus.instr_valid = iv;
    bus.imem_error  = ie;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  function automatic logic [63:0] mdl_read(input int base);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mdl_mem[base + k];
    return w;
  endfunction

  // One complete transaction with expectations derived from the Y86 rules.
  task automatic txn(input string tag, input logic [3:0] ic, input logic [63:0] e,
                     input logic [63:0] a, input logic [63:0] p, input logic iv, input logic ie);
    bit          is_w, is_r, derr, was_halt;
    logic [63:0] addr, wd;
    logic [2:0]  st;
    int          lat, got, base;
    is_w     = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    is_r     = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr     = (ic == 4'h9 || ic == 4'hB) ? a : e;
    wd       = (ic == 4'h8) ? p : a;
    derr     = (is_w || is_r) && (addr > 64'd1016);
    if (ie)             st = 3'd3;
    else if (!iv)       st = 3'd4;
    else if (derr)      st = 3'd3;
    else if (ic == 4'h0) st = 3'd2;
    else                st = 3'd1;
    was_halt = mdl_halt;
    base     = int'(addr[9:0]);
    if (was_halt) lat = 0;
    else if (st == 3'd1 && is_w) lat = 9;
    else if (st == 3'd1 && is_r) lat = 10;
    else lat = 1;
    if (!was_halt) begin
      if (st == 3'd1 && is_w) for (int k = 0; k < 8; k++) mdl_mem[base + k] = wd[8*k +: 8];
      if (st == 3'd1 && is_r) mdl_valm = mdl_read(base);
      if (st != 3'd1) mdl_halt = 1'b1;
    end

    drive_start(ic, e, a, p, iv, ie);
    check_val({tag, " busy"}, bus.busy, was_halt ? 64'd0 : 64'd1);
    got = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        got = n;
        break;
      end
    end
    check_val({tag, " latency"}, 64'(got), 64'(lat));
    if (got != 0) begin
      check_val({tag, " stat"}, bus.stat, 64'(st));
      check_val({tag, " valM"}, bus.valM, mdl_valm);
      check_val({tag, " halted"}, bus.halted, 64'(mdl_halt));
      check_val({tag, " busy@done"}, bus.busy, 64'd0);
      @(posedge clk); #1;
      check_val({tag, " done pulse"}, bus.done, 64'd0);
    end else begin
      check_val({tag, " halted"}, bus.halted, 64'(mdl_halt));
      check_val({tag, " busy idle"}, bus.busy, 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ics [12] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h0, 4'h1, 4'h5, 4'hB, 4'h4};
    logic [63:0] x, y, z, addr, e, a;
    int          dones;
    logic [3:0]  ic;

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.icode       = 4'h1;
    bus.valE        = '0;
    bus.valA        = '0;
    bus.valP        = '0;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    do_reset();

    // Fill all of memory so every later read has a known expectation.
    for (int i = 0; i < 128; i++) txn("init", 4'h4, 64'(i * 8), {$urandom, $urandom}, 64'd0, 1'b1, 1'b0);

    // rmmovq / mrmovq round trip, plus unaligned reads across it
    txn("rmmovq",    4'h4, 64'h10, 64'h1122334455667788, 64'd0, 1'b1, 1'b0);
    txn("mrmovq",    4'h5, 64'h10, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("mrmovq+7",  4'h5, 64'h17, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("mrmovq-7",  4'h5, 64'h09, 64'd0, 64'd0, 1'b1, 1'b0);

    // stack operations
    txn("pushq", 4'hA, 64'h3F8, 64'hAB, 64'd0, 1'b1, 1'b0);
    txn("popq",  4'hB, 64'd0, 64'h3F8, 64'd0, 1'b1, 1'b0);
    txn("call",  4'h8, 64'h3F0, 64'h55, 64'h40, 1'b1, 1'b0);
    txn("ret",   4'h9, 64'd0, 64'h3F0, 64'd0, 1'b1, 1'b0);

    // bounds
    txn("rd top",   4'h5, 64'h3F8, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("wr oob",   4'h4, 64'h3F9, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b1, 1'b0);
    do_reset();
    txn("rd after oob", 4'h5, 64'h3F8, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("rd huge",  4'h5, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1, 1'b0);
    do_reset();

    // halt, ignored start while halted, illegal instruction, fetch error
    txn("halt",     4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("halted start", 4'h5, 64'h10, 64'd0, 64'd0, 1'b1, 1'b0);
    do_reset();
    txn("ins",      4'h4, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0);
    do_reset();
    txn("rd ins",   4'h5, 64'h20, 64'd0, 64'd0, 1'b1, 1'b0);
    txn("imem err", 4'h4, 64'h28, 64'h77, 64'd0, 1'b1, 1'b1);
    do_reset();
    txn("rd imem",  4'h5, 64'h28, 64'd0, 64'd0, 1'b1, 1'b0);

    // second start during write beat 3 must be ignored
    x = 64'hA1A2A3A4A5A6A7A8;
    y = 64'h5555555555555555;
    drive_start(4'h4, 64'h40, x, 64'd0, 1'b1, 1'b0);
    dones = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
      if (n == 3) begin
        bus.valA  = y;
        bus.start = 1'b1;
      end
      if (n == 4) bus.start = 1'b0;
    end
    check_val("restart dones", 64'(dones), 64'd1);
    for (int k = 0; k < 8; k++) mdl_mem[64 + k] = x[8*k +: 8];
    txn("rd restart", 4'h5, 64'h40, 64'd0, 64'd0, 1'b1, 1'b0);

    // reset during write beat 5 keeps bytes 0..4 only
    z = 64'h0F0E0D0C0B0A0908;
    drive_start(4'h4, 64'h100, z, 64'd0, 1'b1, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("abort busy", bus.busy, 64'd0);
    check_val("abort done", bus.done, 64'd0);
    check_val("abort valM", bus.valM, 64'd0);
    reset = 1'b0;
    mdl_valm = 64'd0;
    mdl_halt = 1'b0;
    for (int k = 0; k < 5; k++) mdl_mem[256 + k] = z[8*k +: 8];
    txn("rd abort", 4'h5, 64'h100, 64'd0, 64'd0, 1'b1, 1'b0);

    // no-access instruction leaves valM alone
    txn("opq", 4'h6, 64'h12345, 64'h6789, 64'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      if (mdl_halt && $urandom_range(0, 1) == 1) do_reset();
      ic = ics[$urandom_range(0, 11)];
      case ($urandom_range(0, 19))
        0:       addr = 64'(1017 + $urandom_range(0, 6));
        1:       addr = {32'hFFFFFFFF, $urandom};
        default: addr = 64'($urandom_range(0, 1016));
      endcase
      if (ic == 4'h9 || ic == 4'hB) begin
        a = addr;
        e = {$urandom, $urandom};
      end else begin
        e = addr;
        a = {$urandom, $urandom};
      end
      txn("rand", ic, e, a, {$urandom, $urandom},
          $urandom_range(0, 15) != 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
